// File: rtl/ps2_pkg.sv
// ps2_pkg: shared constants and types for the PS/2 keyboard decoder.
// Prefix codes, frame geometry and the prefix FSM state encoding.
package ps2_pkg;

    localparam logic [7:0] PS2_EXT = 8'hE0;
    localparam logic [7:0] PS2_BRK = 8'hF0;

    localparam int unsigned FRAME_LEN = 11;
    localparam logic [3:0] LAST_BIT = 4'(FRAME_LEN - 1);

    typedef enum logic [1:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK
    } pfx_state_e;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == PS2_EXT) || (b == PS2_BRK);
    endfunction

endpackage

// File: rtl/ps2_frame_rx.sv
// ps2_frame_rx: synchronises the PS/2 pins and deframes 11-bit frames.
// Emits a byte strobe for good frames and an error pulse otherwise.
module ps2_frame_rx
    import ps2_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] rx_byte,
    output logic       byte_stb,
    output logic       frame_err,
    output logic       tmo
);

    logic        clk_s1;
    logic        clk_s2;
    logic        clk_s3;
    logic        dat_s1;
    logic        dat_s2;
    logic        fall;
    logic        last_bit;
    logic        frame_ok;
    logic [3:0]  bitcnt;
    logic [9:0]  shreg;
    logic [15:0] idle;

    // Two-flop synchronisers, plus a third clock flop for edge detection.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            clk_s1 <= 1'b1;
            clk_s2 <= 1'b1;
            clk_s3 <= 1'b1;
            dat_s1 <= 1'b1;
            dat_s2 <= 1'b1;
        end else begin
            clk_s1 <= ps2_clk;
            clk_s2 <= clk_s1;
            clk_s3 <= clk_s2;
            dat_s1 <= ps2_data;
            dat_s2 <= dat_s1;
        end
    end

    // Frame check on the stop-bit edge; shreg holds start, d[7:0], parity.
    always_comb begin
        fall     = clk_s3 & ~clk_s2;
        last_bit = fall && (bitcnt == LAST_BIT);
        frame_ok = ~shreg[0] & dat_s2 & (^shreg[9:1]);
        tmo      = ~fall && (bitcnt != 4'd0) && (idle == TIMEOUT);
        rx_byte  = shreg[8:1];
        byte_stb = last_bit & frame_ok;
        frame_err = (last_bit & ~frame_ok) | tmo;
    end

    // Bit counter and LSB-first shift register, advanced on falling edges.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            bitcnt <= 4'd0;
            shreg  <= 10'd0;
        end else if (fall) begin
            if (last_bit) begin
                bitcnt <= 4'd0;
            end else begin
                bitcnt <= bitcnt + 4'd1;
                shreg  <= {dat_s2, shreg[9:1]};
            end
        end else if (tmo) begin
            bitcnt <= 4'd0;
        end
    end

    // Inactivity counter; runs only while a frame is partly received.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            idle <= 16'd0;
        end else if (fall || bitcnt == 4'd0 || tmo) begin
            idle <= 16'd0;
        end else begin
            idle <= idle + 16'd1;
        end
    end

endmodule

// File: rtl/ps2_kbd_decoder.sv
// ps2_kbd_decoder: folds E0/F0 prefixes into single key events.
// Holds the prefix FSM, the event register and the status counters.
module ps2_kbd_decoder
    import ps2_pkg::*;
#(
    parameter logic [15:0] TIMEOUT = 16'd5000
) (
    input  logic       clk,
    input  logic       clrn,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       ev_ready,
    output logic       ev_valid,
    output logic [7:0] code,
    output logic       ext,
    output logic       released,
    output logic [7:0] press_count,
    output logic       frame_err,
    output logic       overflow
);

    logic [7:0] rx_byte;
    logic       byte_stb;
    logic       rx_err;
    logic       tmo;
    logic       b_ext;
    logic       b_brk;
    logic       emit;
    logic       em_ext;
    logic       em_rel;
    logic       pfx_err;
    logic       load;
    logic       drop;

    pfx_state_e state;
    pfx_state_e nxt;

    ps2_frame_rx #(
        .TIMEOUT (TIMEOUT)
    ) u_rx (
        .clk       (clk),
        .clrn      (clrn),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .rx_byte   (rx_byte),
        .byte_stb  (byte_stb),
        .frame_err (rx_err),
        .tmo       (tmo)
    );

    // Prefix decode: next state and the event to emit for this byte.
    always_comb begin
        nxt     = state;
        emit    = 1'b0;
        em_ext  = 1'b0;
        em_rel  = 1'b0;
        pfx_err = 1'b0;
        b_ext   = (rx_byte == PS2_EXT);
        b_brk   = (rx_byte == PS2_BRK);
        if (byte_stb) begin
            unique case (state)
                IDLE: begin
                    unique case (1'b1)
                        b_ext:   nxt = EXT;
                        b_brk:   nxt = BRK;
                        default: emit = 1'b1;
                    endcase
                end
                EXT: begin
                    unique case (1'b1)
                        b_ext:   nxt = EXT;
                        b_brk:   nxt = EXT_BRK;
                        default: begin
                            emit   = 1'b1;
                            em_ext = 1'b1;
                            nxt    = IDLE;
                        end
                    endcase
                end
                BRK, EXT_BRK: begin
                    nxt = IDLE;
                    if (is_prefix(rx_byte)) begin
                        pfx_err = 1'b1;
                    end else begin
                        emit   = 1'b1;
                        em_rel = 1'b1;
                        em_ext = (state == EXT_BRK);
                    end
                end
                default: nxt = IDLE;
            endcase
        end
        load = emit & (~ev_valid | ev_ready);
        drop = emit & ev_valid & ~ev_ready;
    end

    // Prefix FSM state; an abandoned frame also abandons any prefix.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            state <= IDLE;
        end else if (tmo) begin
            state <= IDLE;
        end else begin
            state <= nxt;
        end
    end

    // Single-entry event register; new events are dropped while it is full.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ev_valid <= 1'b0;
            code     <= 8'h00;
            ext      <= 1'b0;
            released <= 1'b0;
        end else if (load) begin
            ev_valid <= 1'b1;
            code     <= rx_byte;
            ext      <= em_ext;
            released <= em_rel;
        end else if (ev_ready) begin
            ev_valid <= 1'b0;
        end
    end

    // Make counter, sticky overflow and the registered error pulse.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            press_count <= 8'h00;
            overflow    <= 1'b0;
            frame_err   <= 1'b0;
        end else begin
            if (load && !em_rel) begin
                press_count <= press_count + 8'h01;
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            frame_err <= rx_err | pfx_err;
        end
    end

endmodule

// File: tb/tb_ps2_kbd_decoder.sv
// tb_ps2_kbd_decoder: directed PS/2 frames with hand-computed results.
// Checks events, counters, error pulses, timeout and async reset.
module tb_ps2_kbd_decoder;

    localparam int HALF = 20;

    logic       clk = 1'b0;
    logic       clrn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       ev_ready = 1'b0;
    logic       ev_valid;
    logic [7:0] code;
    logic       ext;
    logic       released;
    logic [7:0] press_count;
    logic       frame_err;
    logic       overflow;

    int   checks = 0;
    int   errors = 0;
    int   err_pulses = 0;
    int   wide = 0;
    logic fe_q = 1'b0;
    logic lat2 = 1'b0;
    logic lat3 = 1'b0;

    ps2_kbd_decoder dut (
        .clk         (clk),
        .clrn        (clrn),
        .ps2_clk     (ps2_clk),
        .ps2_data    (ps2_data),
        .ev_ready    (ev_ready),
        .ev_valid    (ev_valid),
        .code        (code),
        .ext         (ext),
        .released    (released),
        .press_count (press_count),
        .frame_err   (frame_err),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    // Count frame_err pulses and any pulse longer than one cycle.
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
        if (frame_err && fe_q) wide++;
        fe_q = frame_err;
    end

    task automatic check(input string tag, input logic [15:0] obs,
                         input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b, input logic flip,
                        input int nbits);
        logic [10:0] f;
        f = {1'b1, ~(^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            ps2_data = f[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            for (int k = 1; k <= HALF; k++) begin
                @(negedge clk);
                if (i == 10 && k == 2) lat2 = ev_valid;
                if (i == 10 && k == 3) lat3 = ev_valid;
            end
            ps2_clk = 1'b1;
        end
        @(negedge clk);
        ps2_data = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic consume();
        @(negedge clk);
        ev_ready = 1'b1;
        @(negedge clk);
        ev_ready = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, ".valid"}, 16'(ev_valid), 16'h0);
        check({tag, ".code"}, 16'(code), 16'h00);
        check({tag, ".ext"}, 16'(ext), 16'h0);
        check({tag, ".rel"}, 16'(released), 16'h0);
        check({tag, ".cnt"}, 16'(press_count), 16'h00);
        check({tag, ".ferr"}, 16'(frame_err), 16'h0);
        check({tag, ".ovf"}, 16'(overflow), 16'h0);
    endtask

    task automatic check_ev(input string tag, input logic [7:0] c,
                            input logic e, input logic r,
                            input logic [7:0] n);
        check({tag, ".valid"}, 16'(ev_valid), 16'h1);
        check({tag, ".code"}, 16'(code), 16'(c));
        check({tag, ".ext"}, 16'(ext), 16'(e));
        check({tag, ".rel"}, 16'(released), 16'(r));
        check({tag, ".cnt"}, 16'(press_count), 16'(n));
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_reset("rst");
        clrn = 1'b1;
        repeat (5) @(negedge clk);

        send(8'h1C, 1'b0, 11);
        check("lat.n2", 16'(lat2), 16'h0);
        check("lat.n3", 16'(lat3), 16'h1);
        check_ev("make", 8'h1C, 1'b0, 1'b0, 8'd1);
        consume();
        check("make.consumed", 16'(ev_valid), 16'h0);

        send(8'hF0, 1'b0, 11);
        check("brk.pfx", 16'(ev_valid), 16'h0);
        send(8'h1C, 1'b0, 11);
        check_ev("brk", 8'h1C, 1'b0, 1'b1, 8'd1);
        consume();

        send(8'hE0, 1'b0, 11);
        check("xb.e0", 16'(ev_valid), 16'h0);
        send(8'hF0, 1'b0, 11);
        check("xb.f0", 16'(ev_valid), 16'h0);
        send(8'h75, 1'b0, 11);
        check_ev("xbrk", 8'h75, 1'b1, 1'b1, 8'd1);
        consume();
        check("pre.errs", 16'(err_pulses), 16'd0);

        send(8'h1C, 1'b1, 11);
        check("par.errs", 16'(err_pulses), 16'd1);
        check("par.noev", 16'(ev_valid), 16'h0);
        send(8'h32, 1'b0, 11);
        check_ev("par.next", 8'h32, 1'b0, 1'b0, 8'd2);
        consume();

        send(8'hF0, 1'b0, 11);
        send(8'hE0, 1'b0, 11);
        check("bad.errs", 16'(err_pulses), 16'd2);
        check("bad.noev", 16'(ev_valid), 16'h0);
        send(8'h1C, 1'b0, 11);
        check_ev("bad.next", 8'h1C, 1'b0, 1'b0, 8'd3);
        consume();

        send(8'h1C, 1'b0, 11);
        send(8'h32, 1'b0, 11);
        check_ev("ovf", 8'h1C, 1'b0, 1'b0, 8'd4);
        check("ovf.flag", 16'(overflow), 16'h1);
        consume();
        check("ovf.consumed", 16'(ev_valid), 16'h0);

        send(8'hE0, 1'b0, 11);
        send(8'h00, 1'b0, 5);
        repeat (5010) @(negedge clk);
        check("tmo.errs", 16'(err_pulses), 16'd3);
        check("tmo.noev", 16'(ev_valid), 16'h0);
        send(8'h1C, 1'b0, 11);
        check_ev("tmo.next", 8'h1C, 1'b0, 1'b0, 8'd5);
        check("tmo.ovf", 16'(overflow), 16'h1);
        check("wide", 16'(wide), 16'd0);

        send(8'h00, 1'b0, 5);
        @(negedge clk);
        clrn = 1'b0;
        #1;
        check_reset("arst");
        @(negedge clk);
        clrn = 1'b1;
        repeat (5) @(negedge clk);
        send(8'h1C, 1'b0, 11);
        check_ev("post", 8'h1C, 1'b0, 1'b0, 8'd1);
        check("post.errs", 16'(err_pulses), 16'd3);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
